max_row_sender: RTL and testbench

MAX_ROW_SENDER -- requirements
Module: max_row_sender

---
 rtl/max_fwd_pkg.sv | 23 ++
 rtl/max_reduce_tree.sv | 47 ++++
 rtl/max_row_sender.sv | 192 +++++++++++++++++++
 tb/tb_max_row_sender.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max_fwd_pkg.sv
// Shared constants, FSM state type and group-length helper for the max row sender.
package max_fwd_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int LANES_DEF  = 64;
  localparam int MODE_W     = 4;
  localparam int PART_N     = 8;

  localparam logic [MODE_W-1:0] MODE_ONE_MAX = 4'd2;
  localparam logic [MODE_W-1:0] MODE_GRP_MAX = 4'd13;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_GRP = 1'b1
  } state_e;

  // Modes outside 3..13 (including the illegal 14/15) form single-row groups.
  function automatic logic [MODE_W-1:0] rows_in_group(input logic [MODE_W-1:0] mode);
    if (mode <= MODE_ONE_MAX || mode > MODE_GRP_MAX) return 4'd1;
    return mode - 4'd1;
  endfunction

endpackage

// File: rtl/max_reduce_tree.sv
// Combinational signed LANES-to-1 maximum, split into 8 partial maxima so a
// register stage can be inserted between the two halves of the tree.
module max_reduce_tree
  import max_fwd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF
) (
  input  logic [LANES*DATA_W-1:0]  row_flat_i,
  output logic [PART_N*DATA_W-1:0] part_flat_o,
  input  logic [PART_N*DATA_W-1:0] part_flat_i,
  output logic [DATA_W-1:0]        max_o
);

  // LANES is expected to be a multiple of PART_N.
  localparam int GRP = LANES / PART_N;

  logic signed [DATA_W-1:0] part_best;
  logic signed [DATA_W-1:0] part_lane;
  logic signed [DATA_W-1:0] fin_best;
  logic signed [DATA_W-1:0] fin_cand;

  always_comb begin
    part_flat_o = '0;
    part_best   = '0;
    part_lane   = '0;
    for (int g = 0; g < PART_N; g++) begin
      part_best = $signed(row_flat_i[g*GRP*DATA_W +: DATA_W]);
      for (int j = 1; j < GRP; j++) begin
        part_lane = $signed(row_flat_i[(g*GRP+j)*DATA_W +: DATA_W]);
        if (part_lane > part_best) part_best = part_lane;
      end
      part_flat_o[g*DATA_W +: DATA_W] = part_best;
    end
  end

  always_comb begin
    fin_best = $signed(part_flat_i[DATA_W-1:0]);
    fin_cand = '0;
    for (int g = 1; g < PART_N; g++) begin
      fin_cand = $signed(part_flat_i[g*DATA_W +: DATA_W]);
      if (fin_cand > fin_best) fin_best = fin_cand;
    end
    max_o = fin_best;
  end

endmodule

// File: rtl/max_row_sender.sv
// Row-max sender: groups incoming rows by length mode and forwards each row with
// its signed maximum. Define MAX_ROW_SENDER_PIPE2_EN for a 2-edge latency build.
// Handshake: a row transfers on a rising edge where i_valid and o_ready are both
// high; o_ready simply mirrors i_en, and o_valid_max is a one-cycle pulse per row.
module max_row_sender
  import max_fwd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [LANES*DATA_W-1:0] i_row_flat,
  input  logic [MODE_W-1:0]       i_length_mode,
  output logic                    o_valid_max,
  output logic [DATA_W-1:0]       o_loc_max,
  output logic [MODE_W-1:0]       o_length_mode,
  output logic [LANES*DATA_W-1:0] o_in_flat,
  output logic                    o_last,
  output logic                    o_mode_err,
  output logic [7:0]              o_grp_cnt,
  output logic                    o_dbg_state
);

  localparam int FLAT_W = LANES * DATA_W;

  state_e              state_q, state_d;
  logic [MODE_W-1:0]   rows_left_q, rows_left_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [MODE_W-1:0]   grp_rows;
  logic [MODE_W-1:0]   row_mode;
  logic                row_last;
  logic                row_err;
  logic                accept;

  assign o_ready     = i_en;
  assign accept      = i_valid & i_en;
  assign o_dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    rows_left_d = rows_left_q;
    mode_d      = mode_q;
    row_mode    = mode_q;
    row_last    = 1'b0;
    row_err     = 1'b0;
    grp_rows    = rows_in_group(i_length_mode);
    case (state_q)
      IDLE: begin
        if (accept) begin
          row_mode    = i_length_mode;
          mode_d      = i_length_mode;
          rows_left_d = grp_rows - 4'd1;
          row_last    = (grp_rows == 4'd1);
          row_err     = (i_length_mode > MODE_GRP_MAX);
          if (grp_rows != 4'd1) state_d = IN_GRP;
        end
      end
      IN_GRP: begin
        if (accept) begin
          rows_left_d = rows_left_q - 4'd1;
          row_last    = (rows_left_q == 4'd1);
          if (rows_left_q == 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      rows_left_q <= '0;
      mode_q      <= '0;
    end else begin
      state_q     <= state_d;
      rows_left_q <= rows_left_d;
      mode_q      <= mode_d;
    end
  end

  logic [PART_N*DATA_W-1:0] part_flat;
  logic [PART_N*DATA_W-1:0] part_sel;
  logic [DATA_W-1:0]        max_final;

  max_reduce_tree #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_tree (
    .row_flat_i  (i_row_flat),
    .part_flat_o (part_flat),
    .part_flat_i (part_sel),
    .max_o       (max_final)
  );

  logic              out_valid;
  logic              out_last;
  logic              out_err;
  logic [MODE_W-1:0] out_mode;
  logic [FLAT_W-1:0] out_flat;

`ifdef MAX_ROW_SENDER_PIPE2_EN
  logic                     s1_valid_q;
  logic                     s1_last_q;
  logic                     s1_err_q;
  logic [MODE_W-1:0]        s1_mode_q;
  logic [FLAT_W-1:0]        s1_flat_q;
  logic [PART_N*DATA_W-1:0] s1_part_q;

  // The in-flight row is frozen while i_en is low and drains once it returns.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_mode_q  <= '0;
      s1_flat_q  <= '0;
      s1_part_q  <= '0;
    end else if (i_en) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q <= row_last;
        s1_err_q  <= row_err;
        s1_mode_q <= row_mode;
        s1_flat_q <= i_row_flat;
        s1_part_q <= part_flat;
      end
    end
  end

  assign part_sel  = s1_part_q;
  assign out_valid = s1_valid_q;
  assign out_last  = s1_last_q;
  assign out_err   = s1_err_q;
  assign out_mode  = s1_mode_q;
  assign out_flat  = s1_flat_q;
`else
  assign part_sel  = part_flat;
  assign out_valid = accept;
  assign out_last  = row_last;
  assign out_err   = row_err;
  assign out_mode  = row_mode;
  assign out_flat  = i_row_flat;
`endif

  logic              valid_q;
  logic              last_q;
  logic              err_q;
  logic [DATA_W-1:0] loc_max_q;
  logic [MODE_W-1:0] len_mode_q;
  logic [FLAT_W-1:0] flat_q;
  logic [7:0]        grp_cnt_q;

  // Pulses are forced low while disabled; data registers keep their last row.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      loc_max_q  <= '0;
      len_mode_q <= '0;
      flat_q     <= '0;
      grp_cnt_q  <= '0;
    end else if (!i_en) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= out_valid;
      last_q  <= out_valid & out_last;
      err_q   <= out_valid & out_err;
      if (out_valid) begin
        loc_max_q  <= max_final;
        len_mode_q <= out_mode;
        flat_q     <= out_flat;
        if (out_last) grp_cnt_q <= grp_cnt_q + 8'd1;
      end
    end
  end

  assign o_valid_max   = valid_q;
  assign o_last        = last_q;
  assign o_mode_err    = err_q;
  assign o_loc_max     = loc_max_q;
  assign o_length_mode = len_mode_q;
  assign o_in_flat     = flat_q;
  assign o_grp_cnt     = grp_cnt_q;

endmodule

// File: tb/tb_max_row_sender.sv
// Directed bench for max_row_sender; scenario tasks compare captured output rows
// against hand-computed expectations. Works for both latency builds.
module tb_max_row_sender;

  localparam int DW   = 16;
  localparam int LN   = 64;
  localparam int FLAT = DW * LN;
`ifdef MAX_ROW_SENDER_PIPE2_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic            i_clk;
  logic            i_rst_n;
  logic            i_en;
  logic            i_valid;
  logic            o_ready;
  logic [FLAT-1:0] i_row_flat;
  logic [3:0]      i_length_mode;
  logic            o_valid_max;
  logic [DW-1:0]   o_loc_max;
  logic [3:0]      o_length_mode;
  logic [FLAT-1:0] o_in_flat;
  logic            o_last;
  logic            o_mode_err;
  logic [7:0]      o_grp_cnt;
  logic            o_dbg_state;

  max_row_sender #(.DATA_W(DW), .LANES(LN)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (i_en),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_row_flat    (i_row_flat),
    .i_length_mode (i_length_mode),
    .o_valid_max   (o_valid_max),
    .o_loc_max     (o_loc_max),
    .o_length_mode (o_length_mode),
    .o_in_flat     (o_in_flat),
    .o_last        (o_last),
    .o_mode_err    (o_mode_err),
    .o_grp_cnt     (o_grp_cnt),
    .o_dbg_state   (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  typedef struct {
    logic [DW-1:0]   mx;
    logic [3:0]      mode;
    logic            last;
    logic            err;
    logic [FLAT-1:0] flat;
    int              cyc;
  } obs_t;

  obs_t got_q[$];
  int   stray = 0;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] exp_grp = 8'd0;

  always @(posedge i_clk) begin
    obs_t o;
    #1;
    if (o_valid_max) begin
      o.mx = o_loc_max; o.mode = o_length_mode; o.last = o_last;
      o.err = o_mode_err; o.flat = o_in_flat; o.cyc = cyc;
      got_q.push_back(o);
    end else if (o_last || o_mode_err) begin
      stray++;
    end
  end

  // ---------------- helpers / drivers ----------------
  function automatic logic [FLAT-1:0] fill(input logic [DW-1:0] v);
    logic [FLAT-1:0] r;
    for (int k = 0; k < LN; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  task automatic drive_row(input logic [FLAT-1:0] row, input logic [3:0] mode, output int acc);
    i_valid = 1'b1;
    i_row_flat = row;
    i_length_mode = mode;
    @(posedge i_clk); #1;
    acc = cyc;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge i_clk);
    total++; if (o_valid_max !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", o_valid_max); end
    total++; if (o_loc_max !== 16'h0) begin bad++; $display("FAIL reset_loc_max got=%h want=0000", o_loc_max); end
    total++; if (o_length_mode !== 4'h0) begin bad++; $display("FAIL reset_mode got=%h want=0", o_length_mode); end
    total++; if (o_in_flat !== '0) begin bad++; $display("FAIL reset_flat got_lane0=%h want=0", o_in_flat[15:0]); end
    total++; if ({o_last, o_mode_err} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b want=00", {o_last, o_mode_err}); end
    total++; if (o_grp_cnt !== 8'd0) begin bad++; $display("FAIL reset_grp_cnt got=%0d want=0", o_grp_cnt); end
    total++; if (o_dbg_state !== 1'b0) begin bad++; $display("FAIL reset_state got=%0b want=0", o_dbg_state); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL ready_en1 got=%0b want=1", o_ready); end
    i_en = 1'b0; #1;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL ready_en0 got=%0b want=0", o_ready); end
    i_en = 1'b1;
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_mode3();
    int acc[2];
    logic [21:0] exp_q[$];
    got_q.delete();
    drive_row(fill(16'd100), 4'd3, acc[0]);
    drive_row(fill(16'd101), 4'd3, acc[1]);
    idle(3);
    exp_q = '{ {16'd100, 4'd3, 1'b0, 1'b0}, {16'd101, 4'd3, 1'b1, 1'b0} };
    exp_grp += 8'd1;
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL m3_count got=%0d want=2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      total++; if ({got_q[i].mx, got_q[i].mode, got_q[i].last, got_q[i].err} !== exp_q[i]) begin
        bad++; $display("FAIL m3_row%0d got=%h/%0d/%b/%b want=%h", i, got_q[i].mx, got_q[i].mode, got_q[i].last, got_q[i].err, exp_q[i]);
      end
      total++; if (got_q[i].cyc != acc[i] + EXTRA) begin bad++; $display("FAIL m3_lat%0d got=%0d want=%0d", i, got_q[i].cyc, acc[i] + EXTRA); end
      total++; if (got_q[i].flat !== fill(16'(100 + i))) begin bad++; $display("FAIL m3_flat%0d got_lane0=%h", i, got_q[i].flat[15:0]); end
    end
    total++; if (o_grp_cnt !== exp_grp) begin bad++; $display("FAIL m3_grp_cnt got=%0d want=%0d", o_grp_cnt, exp_grp); end
  endtask

  task automatic test_mode13_ignore_mode();
    int acc[16];
    logic [21:0] exp_q[$];
    logic [15:0] v;
    got_q.delete();
    for (int i = 0; i < 12; i++) begin
      v = 16'(i * 300 - 2000);
      drive_row(fill(v), (i < 3) ? 4'd13 : 4'd5, acc[i]);
      exp_q.push_back({v, 4'd13, (i == 11), 1'b0});
      if (i == 6) begin
        idle(2);
        total++; if (o_dbg_state !== 1'b1) begin bad++; $display("FAIL m13_gap_state got=%0b want=1", o_dbg_state); end
      end
    end
    for (int j = 0; j < 4; j++) begin
      v = 16'(500 + j);
      drive_row(fill(v), (j == 0) ? 4'd5 : 4'd9, acc[12+j]);
      exp_q.push_back({v, 4'd5, (j == 3), 1'b0});
    end
    idle(3);
    exp_grp += 8'd2;
    total++; if (got_q.size() != 16) begin bad++; $display("FAIL m13_count got=%0d want=16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      total++; if ({got_q[i].mx, got_q[i].mode, got_q[i].last, got_q[i].err} !== exp_q[i]) begin
        bad++; $display("FAIL m13_row%0d got=%h/%0d/%b/%b want=%h", i, got_q[i].mx, got_q[i].mode, got_q[i].last, got_q[i].err, exp_q[i]);
      end
      total++; if (got_q[i].cyc != acc[i] + EXTRA) begin bad++; $display("FAIL m13_lat%0d got=%0d want=%0d", i, got_q[i].cyc, acc[i] + EXTRA); end
    end
    total++; if (o_grp_cnt !== exp_grp) begin bad++; $display("FAIL m13_grp_cnt got=%0d want=%0d", o_grp_cnt, exp_grp); end
    total++; if (o_dbg_state !== 1'b0) begin bad++; $display("FAIL m13_end_state got=%0b want=0", o_dbg_state); end
  endtask

  task automatic test_short_modes();
    int acc[3];
    logic [21:0] exp_q[$];
    got_q.delete();
    drive_row(fill(16'hFFFF), 4'd0, acc[0]);
    drive_row(fill(16'h0000), 4'd1, acc[1]);
    drive_row(fill(16'h0001), 4'd2, acc[2]);
    idle(3);
    exp_q = '{ {16'hFFFF, 4'd0, 1'b1, 1'b0}, {16'h0000, 4'd1, 1'b1, 1'b0}, {16'h0001, 4'd2, 1'b1, 1'b0} };
    exp_grp += 8'd3;
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL short_count got=%0d want=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      total++; if ({got_q[i].mx, got_q[i].mode, got_q[i].last, got_q[i].err} !== exp_q[i]) begin
        bad++; $display("FAIL short_row%0d got=%h/%0d/%b/%b want=%h", i, got_q[i].mx, got_q[i].mode, got_q[i].last, got_q[i].err, exp_q[i]);
      end
      total++; if (got_q[i].cyc != acc[i] + EXTRA) begin bad++; $display("FAIL short_lat%0d got=%0d want=%0d", i, got_q[i].cyc, acc[i] + EXTRA); end
    end
    total++; if (o_grp_cnt !== exp_grp) begin bad++; $display("FAIL short_grp_cnt got=%0d want=%0d", o_grp_cnt, exp_grp); end
  endtask

  task automatic test_signed_max();
    int acc;
    logic [FLAT-1:0] r[3];
    logic [15:0] exp_mx[3];
    got_q.delete();
    r[0] = fill(16'hFFFB); r[0][63*DW +: DW] = 16'hFFFF;
    r[1] = fill(16'h8000); r[1][DW-1:0] = 16'h7FFF;
    r[2] = fill(16'hFFFB); r[2][29*DW +: DW] = 16'd1234;
    exp_mx = '{16'hFFFF, 16'h7FFF, 16'd1234};
    for (int i = 0; i < 3; i++) drive_row(r[i], 4'd0, acc);
    idle(3);
    exp_grp += 8'd3;
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL signed_count got=%0d want=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      total++; if (got_q[i].mx !== exp_mx[i]) begin bad++; $display("FAIL signed_max%0d got=%h want=%h", i, got_q[i].mx, exp_mx[i]); end
      total++; if (got_q[i].flat !== r[i]) begin bad++; $display("FAIL signed_flat%0d got_lane63=%h want=%h", i, got_q[i].flat[63*DW +: DW], r[i][63*DW +: DW]); end
    end
  endtask

  task automatic test_reset_mid_group();
    int acc[3];
    int tmp;
    logic [21:0] exp_q[$];
    for (int i = 0; i < 5; i++) drive_row(fill(16'(10 + i)), 4'd13, tmp);
    idle(EXTRA);
    total++; if (o_valid_max !== 1'b1 || o_loc_max !== 16'd14) begin
      bad++; $display("FAIL pre_reset_row5 got=%0b/%h want=1/000e", o_valid_max, o_loc_max);
    end
    #2 i_rst_n = 1'b0;
    #1;
    total++; if ({o_valid_max, o_last, o_mode_err} !== 3'b000) begin bad++; $display("FAIL rstmid_pulses got=%b want=000", {o_valid_max, o_last, o_mode_err}); end
    total++; if (o_loc_max !== 16'h0 || o_length_mode !== 4'h0) begin bad++; $display("FAIL rstmid_data got=%h/%h want=0/0", o_loc_max, o_length_mode); end
    total++; if (o_in_flat !== '0) begin bad++; $display("FAIL rstmid_flat got_lane0=%h want=0", o_in_flat[15:0]); end
    total++; if (o_grp_cnt !== 8'd0 || o_dbg_state !== 1'b0) begin bad++; $display("FAIL rstmid_cnt_state got=%0d/%0b want=0/0", o_grp_cnt, o_dbg_state); end
    @(negedge i_clk) i_rst_n = 1'b1;
    exp_grp = 8'd0;
    @(posedge i_clk); #1;
    got_q.delete();
    drive_row(fill(16'd7), 4'd4, acc[0]);
    drive_row(fill(16'd8), 4'd13, acc[1]);
    drive_row(fill(16'd9), 4'd13, acc[2]);
    idle(3);
    exp_q = '{ {16'd7, 4'd4, 1'b0, 1'b0}, {16'd8, 4'd4, 1'b0, 1'b0}, {16'd9, 4'd4, 1'b1, 1'b0} };
    exp_grp += 8'd1;
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL m4_count got=%0d want=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      total++; if ({got_q[i].mx, got_q[i].mode, got_q[i].last, got_q[i].err} !== exp_q[i]) begin
        bad++; $display("FAIL m4_row%0d got=%h/%0d/%b/%b want=%h", i, got_q[i].mx, got_q[i].mode, got_q[i].last, got_q[i].err, exp_q[i]);
      end
    end
    total++; if (o_grp_cnt !== exp_grp) begin bad++; $display("FAIL m4_grp_cnt got=%0d want=%0d", o_grp_cnt, exp_grp); end
  endtask

  task automatic test_enable_gap();
    int acc[2];
    logic [21:0] exp_q[$];
    got_q.delete();
    stray = 0;
    drive_row(fill(16'hFFF9), 4'd15, acc[0]);
    i_en = 1'b0;
    i_row_flat = fill(16'd33);
    i_length_mode = 4'd1;
    for (int i = 0; i < 2; i++) begin
      @(posedge i_clk); #1;
      total++; if (o_valid_max !== 1'b0 || o_ready !== 1'b0) begin
        bad++; $display("FAIL en_low%0d valid/ready got=%0b/%0b want=0/0", i, o_valid_max, o_ready);
      end
`ifndef MAX_ROW_SENDER_PIPE2_EN
      total++; if (o_loc_max !== 16'hFFF9) begin bad++; $display("FAIL en_low_hold%0d got=%h want=fff9", i, o_loc_max); end
`endif
    end
    i_en = 1'b1;
    @(posedge i_clk); #1;
    acc[1] = cyc;
    idle(3);
    exp_q = '{ {16'hFFF9, 4'd15, 1'b1, 1'b1}, {16'd33, 4'd1, 1'b1, 1'b0} };
    exp_grp += 8'd2;
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL en_count got=%0d want=2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      total++; if ({got_q[i].mx, got_q[i].mode, got_q[i].last, got_q[i].err} !== exp_q[i]) begin
        bad++; $display("FAIL en_row%0d got=%h/%0d/%b/%b want=%h", i, got_q[i].mx, got_q[i].mode, got_q[i].last, got_q[i].err, exp_q[i]);
      end
    end
    if (got_q.size() == 2) begin
      total++; if (got_q[0].cyc != acc[0] + 3 * EXTRA) begin bad++; $display("FAIL en_lat0 got=%0d want=%0d", got_q[0].cyc, acc[0] + 3 * EXTRA); end
      total++; if (got_q[1].cyc != acc[1] + EXTRA) begin bad++; $display("FAIL en_lat1 got=%0d want=%0d", got_q[1].cyc, acc[1] + EXTRA); end
    end
    total++; if (stray != 0) begin bad++; $display("FAIL en_stray_pulses got=%0d want=0", stray); end
    total++; if (o_grp_cnt !== exp_grp) begin bad++; $display("FAIL en_grp_cnt got=%0d want=%0d", o_grp_cnt, exp_grp); end
  endtask

  task automatic test_grp_wrap();
    int tmp;
    got_q.delete();
    for (int i = 0; i < 256; i++) drive_row(fill(16'(i)), 4'd0, tmp);
    idle(3);
    total++; if (got_q.size() != 256) begin bad++; $display("FAIL wrap_count got=%0d want=256", got_q.size()); end
    total++; if (o_grp_cnt !== exp_grp) begin bad++; $display("FAIL wrap_grp_cnt got=%0d want=%0d", o_grp_cnt, exp_grp); end
    total++; if (stray != 0) begin bad++; $display("FAIL wrap_stray_pulses got=%0d want=0", stray); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    i_rst_n = 1'b0;
    i_en = 1'b1;
    i_valid = 1'b0;
    i_row_flat = '0;
    i_length_mode = 4'd0;
    test_reset();
    test_mode3();
    test_mode13_ignore_mode();
    test_short_modes();
    test_signed_max();
    test_reset_mid_group();
    test_enable_gap();
    test_grp_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
